any1_branch_predictor: RTL and testbench

//  Gshare direction predictor: the producer side of the branch outcome that any1_eval_branch resolves.

---
 rtl/any1_branch_predictor_if.sv | 32 +++
 rtl/any1_branch_predictor.sv | 84 ++++++++
 tb/tb_any1_branch_predictor.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/any1_branch_predictor_if.sv
// any1_branch_predictor_if: fetch-side prediction and execute-side training signals of the gshare predictor
//   rdy_o         predictor table initialised
//   pred_v_i      prediction request, pred_pc_i its PC
//   pred_v_o      prediction valid, pred_taken_o direction, pred_hist_o history used
//   upd_v_i       resolved-branch update, upd_pc_i/upd_hist_i locate the counter
//   upd_takb_i    resolved outcome, upd_mispred_i triggers history repair
interface any1_branch_predictor_if #(
    parameter int AMSB      = 31,
    parameter int HIST_BITS = 8
);
    logic                 rdy_o;
    logic                 pred_v_i;
    logic [AMSB:0]        pred_pc_i;
    logic                 pred_v_o;
    logic                 pred_taken_o;
    logic [HIST_BITS-1:0] pred_hist_o;
    logic                 upd_v_i;
    logic [AMSB:0]        upd_pc_i;
    logic [HIST_BITS-1:0] upd_hist_i;
    logic                 upd_takb_i;
    logic                 upd_mispred_i;

    modport master (
        input  rdy_o, pred_v_o, pred_taken_o, pred_hist_o,
        output pred_v_i, pred_pc_i, upd_v_i, upd_pc_i, upd_hist_i, upd_takb_i, upd_mispred_i
    );

    modport slave (
        output rdy_o, pred_v_o, pred_taken_o, pred_hist_o,
        input  pred_v_i, pred_pc_i, upd_v_i, upd_pc_i, upd_hist_i, upd_takb_i, upd_mispred_i
    );
endinterface

// File: rtl/any1_branch_predictor.sv
// any1_branch_predictor: gshare direction predictor with 2-bit saturating counters and history repair
//   rst_ni  async active-low reset
//   clk_i   clock
//   bp      slave side of any1_branch_predictor_if (prediction request/response, training update)
module any1_branch_predictor #(
    parameter int ENTRIES   = 512,
    parameter int HIST_BITS = 8,
    parameter int AMSB      = 31
) (
    input logic                   rst_ni,
    input logic                   clk_i,
    any1_branch_predictor_if.slave bp
);
    localparam int IDXB = $clog2(ENTRIES);

    typedef enum logic {INIT, RUN} state_e;

    state_e               state_q;
    logic [IDXB-1:0]      init_ptr_q;
    logic [HIST_BITS-1:0] ghist_q, ghist_d, pred_hist_q;
    logic                 rdy_q, pred_v_q, pred_taken_q;
    logic [1:0]           ctr_q [ENTRIES];
    logic [IDXB-1:0]      pidx, uidx;
    logic [1:0]           uold, unew, pctr;
    logic                 run, upd_en, pred_en, repair;
    logic                 unused_pc;

    always_comb begin
        run     = state_q == RUN;
        upd_en  = run && bp.upd_v_i;
        pred_en = run && bp.pred_v_i;
        repair  = upd_en && bp.upd_mispred_i;
        pidx    = bp.pred_pc_i[IDXB+1:2] ^ IDXB'(ghist_q);
        uidx    = bp.upd_pc_i[IDXB+1:2] ^ IDXB'(bp.upd_hist_i);
        uold    = ctr_q[uidx];
        unew    = bp.upd_takb_i ? ((uold == 2'd3) ? 2'd3 : uold + 2'd1)
                                : ((uold == 2'd0) ? 2'd0 : uold - 2'd1);
        // write-first: a same-index update this cycle is visible to the prediction
        pctr    = (upd_en && uidx == pidx) ? unew : ctr_q[pidx];
        // repair beats the speculative shift of a same-cycle prediction
        ghist_d = repair  ? {bp.upd_hist_i[HIST_BITS-2:0], bp.upd_takb_i}
                : pred_en ? {ghist_q[HIST_BITS-2:0], pctr[1]}
                :           ghist_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= INIT;
            init_ptr_q   <= '0;
            rdy_q        <= 1'b0;
            pred_v_q     <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_hist_q  <= '0;
            ghist_q      <= '0;
        end else if (!run) begin
            init_ptr_q <= init_ptr_q + 1'b1;
            if (init_ptr_q == IDXB'(ENTRIES - 1)) begin
                state_q <= RUN;
                rdy_q   <= 1'b1;
            end
        end else begin
            pred_v_q <= bp.pred_v_i;
            if (bp.pred_v_i) begin
                pred_taken_q <= pctr[1];
                pred_hist_q  <= ghist_q;
            end
            ghist_q <= ghist_d;
        end
    end

    // counter table needs no reset: INIT rewrites every entry before RUN
    always_ff @(posedge clk_i) begin
        if (!run) ctr_q[init_ptr_q] <= 2'b01;
        else if (upd_en) ctr_q[uidx] <= unew;
    end

    assign unused_pc = ^{bp.pred_pc_i[AMSB:IDXB+2], bp.pred_pc_i[1:0],
                         bp.upd_pc_i[AMSB:IDXB+2], bp.upd_pc_i[1:0]};

    assign bp.rdy_o        = rdy_q;
    assign bp.pred_v_o     = pred_v_q;
    assign bp.pred_taken_o = pred_taken_q;
    assign bp.pred_hist_o  = pred_hist_q;
endmodule

// File: tb/tb_any1_branch_predictor.sv
// tb_any1_branch_predictor: directed checks of init, saturation, history, repair, collision and reset
module tb_any1_branch_predictor;
    logic clk = 1'b0;
    logic a_rst_n, b_rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    any1_branch_predictor_if #(.AMSB(31), .HIST_BITS(4)) a_if ();
    any1_branch_predictor_if #(.AMSB(31), .HIST_BITS(8)) b_if ();

    any1_branch_predictor #(.ENTRIES(16), .HIST_BITS(4), .AMSB(31)) dut_a (
        .rst_ni(a_rst_n), .clk_i(clk), .bp(a_if.slave)
    );
    any1_branch_predictor #(.ENTRIES(512), .HIST_BITS(8), .AMSB(31)) dut_b (
        .rst_ni(b_rst_n), .clk_i(clk), .bp(b_if.slave)
    );

    task automatic a_pred(input logic [31:0] pc);
        a_if.pred_v_i = 1'b1; a_if.pred_pc_i = pc;
        @(negedge clk);
        a_if.pred_v_i = 1'b0;
    endtask

    task automatic a_upd(input logic [31:0] pc, input logic [3:0] h, input logic t);
        a_if.upd_v_i = 1'b1; a_if.upd_pc_i = pc; a_if.upd_hist_i = h;
        a_if.upd_takb_i = t; a_if.upd_mispred_i = 1'b0;
        @(negedge clk);
        a_if.upd_v_i = 1'b0;
    endtask

    task automatic b_pred(input logic [31:0] pc);
        b_if.pred_v_i = 1'b1; b_if.pred_pc_i = pc;
        @(negedge clk);
        b_if.pred_v_i = 1'b0;
    endtask

    task automatic b_upd(input logic [31:0] pc, input logic [7:0] h, input logic t, input logic m);
        b_if.upd_v_i = 1'b1; b_if.upd_pc_i = pc; b_if.upd_hist_i = h;
        b_if.upd_takb_i = t; b_if.upd_mispred_i = m;
        @(negedge clk);
        b_if.upd_v_i = 1'b0;
    endtask

    task automatic b_both(input logic [31:0] ppc, input logic [31:0] upc, input logic [7:0] h,
                          input logic t, input logic m);
        b_if.pred_v_i = 1'b1; b_if.pred_pc_i = ppc;
        b_if.upd_v_i = 1'b1; b_if.upd_pc_i = upc; b_if.upd_hist_i = h;
        b_if.upd_takb_i = t; b_if.upd_mispred_i = m;
        @(negedge clk);
        b_if.pred_v_i = 1'b0; b_if.upd_v_i = 1'b0;
    endtask

    task automatic test_reset;
        int cnt;
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (a_if.rdy_o !== 1'b0) begin errors++; $display("FAIL reset_rdy: got %b expected 0", a_if.rdy_o); end
        checks++; if (a_if.pred_v_o !== 1'b0) begin errors++; $display("FAIL reset_pred_v: got %b expected 0", a_if.pred_v_o); end
        checks++; if (a_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_taken: got %b expected 0", a_if.pred_taken_o); end
        checks++; if (a_if.pred_hist_o !== 4'h0) begin errors++; $display("FAIL reset_hist: got %h expected 0", a_if.pred_hist_o); end
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_if.pred_v_i = 1'b1; a_if.pred_pc_i = 32'h100;
        cnt = 0;
        while (a_if.rdy_o === 1'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
            checks++; if (a_if.pred_v_o !== 1'b0) begin errors++; $display("FAIL init_pred_v: got %b expected 0 at cycle %0d", a_if.pred_v_o, cnt); end
        end
        a_if.pred_v_i = 1'b0;
        checks++; if (cnt != 16) begin errors++; $display("FAIL init_len: got %0d cycles expected 16", cnt); end
        a_pred(32'h100);
        checks++; if (a_if.pred_v_o !== 1'b1) begin errors++; $display("FAIL first_pred_v: got %b expected 1", a_if.pred_v_o); end
        checks++; if (a_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL first_pred_taken: got %b expected 0", a_if.pred_taken_o); end
        checks++; if (a_if.pred_hist_o !== 4'h0) begin errors++; $display("FAIL first_pred_hist: got %h expected 0", a_if.pred_hist_o); end
    endtask

    task automatic test_mid_reset;
        int cnt;
        a_upd(32'h8, 4'h0, 1'b1);
        a_upd(32'h8, 4'h0, 1'b1);
        a_pred(32'h8);
        checks++; if (a_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL midrst_trained: got %b expected 1", a_if.pred_taken_o); end
        a_rst_n = 1'b0;
        #1;
        checks++; if (a_if.rdy_o !== 1'b0) begin errors++; $display("FAIL midrst_rdy: got %b expected 0", a_if.rdy_o); end
        checks++; if (a_if.pred_v_o !== 1'b0) begin errors++; $display("FAIL midrst_pred_v: got %b expected 0", a_if.pred_v_o); end
        @(negedge clk);
        a_rst_n = 1'b1;
        cnt = 0;
        while (a_if.rdy_o === 1'b0 && cnt < 100) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (cnt != 16) begin errors++; $display("FAIL midrst_init_len: got %0d cycles expected 16", cnt); end
        a_pred(32'h8);
        checks++; if (a_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL midrst_taken: got %b expected 0", a_if.pred_taken_o); end
        checks++; if (a_if.pred_hist_o !== 4'h0) begin errors++; $display("FAIL midrst_hist: got %h expected 0", a_if.pred_hist_o); end
    endtask

    task automatic wait_b_ready;
        int cnt = 0;
        while (b_if.rdy_o !== 1'b1 && cnt < 600) begin
            @(negedge clk);
            cnt++;
        end
        checks++; if (b_if.rdy_o !== 1'b1) begin errors++; $display("FAIL b_ready: got %b expected 1", b_if.rdy_o); end
    endtask

    task automatic test_saturation;
        repeat (4) b_upd(32'h40, 8'h00, 1'b1, 1'b0);
        b_pred(32'h40);
        checks++; if (b_if.pred_v_o !== 1'b1) begin errors++; $display("FAIL sat3_v: got %b expected 1", b_if.pred_v_o); end
        checks++; if (b_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL sat3_taken: got %b expected 1", b_if.pred_taken_o); end
        @(negedge clk);
        checks++; if (b_if.pred_v_o !== 1'b0) begin errors++; $display("FAIL idle_v: got %b expected 0", b_if.pred_v_o); end
        checks++; if (b_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL idle_taken_hold: got %b expected 1", b_if.pred_taken_o); end
        b_upd(32'h7FC, 8'h00, 1'b0, 1'b1);
        b_upd(32'h40, 8'h00, 1'b0, 1'b0);
        b_pred(32'h40);
        checks++; if (b_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL sat2_taken: got %b expected 1", b_if.pred_taken_o); end
        b_upd(32'h7FC, 8'h00, 1'b0, 1'b1);
        b_upd(32'h40, 8'h00, 1'b0, 1'b0);
        b_upd(32'h40, 8'h00, 1'b0, 1'b0);
        b_pred(32'h40);
        checks++; if (b_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat0_taken: got %b expected 0", b_if.pred_taken_o); end
        checks++; if (b_if.pred_hist_o !== 8'h00) begin errors++; $display("FAIL sat0_hist: got %h expected 00", b_if.pred_hist_o); end
    endtask

    task automatic test_back_to_back;
        repeat (3) b_upd(32'h40, 8'h00, 1'b1, 1'b0);
        b_upd(32'h40, 8'h01, 1'b0, 1'b0);
        b_if.pred_v_i = 1'b1; b_if.pred_pc_i = 32'h40;
        @(negedge clk);
        checks++; if (b_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL b2b_first_taken: got %b expected 1", b_if.pred_taken_o); end
        checks++; if (b_if.pred_hist_o !== 8'h00) begin errors++; $display("FAIL b2b_first_hist: got %h expected 00", b_if.pred_hist_o); end
        @(negedge clk);
        b_if.pred_v_i = 1'b0;
        checks++; if (b_if.pred_v_o !== 1'b1) begin errors++; $display("FAIL b2b_second_v: got %b expected 1", b_if.pred_v_o); end
        checks++; if (b_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL b2b_second_taken: got %b expected 0", b_if.pred_taken_o); end
        checks++; if (b_if.pred_hist_o !== 8'h01) begin errors++; $display("FAIL b2b_second_hist: got %h expected 01", b_if.pred_hist_o); end
    endtask

    task automatic test_mispredict;
        b_upd(32'h7FC, 8'h52, 1'b1, 1'b1);
        b_both(32'h200, 32'h7F8, 8'h3C, 1'b1, 1'b1);
        checks++; if (b_if.pred_hist_o !== 8'hA5) begin errors++; $display("FAIL repair_pre_hist: got %h expected a5", b_if.pred_hist_o); end
        b_pred(32'h200);
        checks++; if (b_if.pred_hist_o !== 8'h79) begin errors++; $display("FAIL repair_post_hist: got %h expected 79", b_if.pred_hist_o); end
    endtask

    task automatic test_collision;
        b_upd(32'h7FC, 8'h00, 1'b0, 1'b1);
        b_both(32'h80, 32'h80, 8'h00, 1'b1, 1'b0);
        checks++; if (b_if.pred_taken_o !== 1'b1) begin errors++; $display("FAIL collide_taken: got %b expected 1", b_if.pred_taken_o); end
        checks++; if (b_if.pred_hist_o !== 8'h00) begin errors++; $display("FAIL collide_hist: got %h expected 00", b_if.pred_hist_o); end
        b_both(32'h40, 32'h40, 8'h00, 1'b0, 1'b0);
        checks++; if (b_if.pred_taken_o !== 1'b0) begin errors++; $display("FAIL nocollide_taken: got %b expected 0", b_if.pred_taken_o); end
        checks++; if (b_if.pred_hist_o !== 8'h01) begin errors++; $display("FAIL nocollide_hist: got %h expected 01", b_if.pred_hist_o); end
    endtask

    initial begin
        a_if.pred_v_i = 1'b0; a_if.pred_pc_i = '0; a_if.upd_v_i = 1'b0; a_if.upd_pc_i = '0;
        a_if.upd_hist_i = '0; a_if.upd_takb_i = 1'b0; a_if.upd_mispred_i = 1'b0;
        b_if.pred_v_i = 1'b0; b_if.pred_pc_i = '0; b_if.upd_v_i = 1'b0; b_if.upd_pc_i = '0;
        b_if.upd_hist_i = '0; b_if.upd_takb_i = 1'b0; b_if.upd_mispred_i = 1'b0;
        test_reset();
        test_mid_reset();
        wait_b_ready();
        test_saturation();
        test_back_to_back();
        test_mispredict();
        test_collision();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
